// File: rtl/uart_num_parser.sv
// UART RX byte stream -> signed decimal integer buffer with count/clear/read port.
// Optional terminal echo (CR expands to CR LF) enabled by UART_NUM_PARSER_ECHO_EN.
module uart_num_parser #(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   clear_req,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [31:0]            rd_data,
  output logic [COUNT_WIDTH-1:0] num_count,
  output logic                   overflow,
  output logic                   parse_error,
  output logic [7:0]             echo_data,
  output logic                   echo_valid
);

  typedef enum logic [1:0] {S_GAP, S_NEG, S_NUM, S_BAD} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            acc_q, acc_d;
  logic                   neg_q, neg_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   perr_q, perr_d;
  logic [31:0]            mem_q [DEPTH];
  logic [31:0]            mem_d [DEPTH];
  logic [31:0]            rd_q, rd_d;

  logic        is_dig, is_minus, is_sep;
  logic [31:0] dig, val;

  always_comb begin
    is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_minus = (rx_data == 8'h2D);
    is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C) ||
               (rx_data == 8'h09) || (rx_data == 8'h0D) ||
               (rx_data == 8'h0A);
    dig      = {28'd0, rx_data[3:0]};
    val      = neg_q ? (32'd0 - acc_q) : acc_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    perr_d  = 1'b0;
    mem_d   = mem_q;
    if (clear_req) begin
      state_d = S_GAP;
      acc_d   = '0;
      neg_d   = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rx_valid) begin
      unique case (state_q)
        S_GAP: begin
          unique case (1'b1)
            is_dig: begin
              state_d = S_NUM;
              acc_d   = dig;
              neg_d   = 1'b0;
            end
            is_minus: state_d = S_NEG;
            is_sep:   state_d = S_GAP;
            default: begin
              state_d = S_BAD;
              perr_d  = 1'b1;
            end
          endcase
        end
        S_NEG: begin
          unique case (1'b1)
            is_dig: begin
              state_d = S_NUM;
              acc_d   = dig;
              neg_d   = 1'b1;
            end
            is_sep: begin
              state_d = S_GAP;
              perr_d  = 1'b1;
            end
            default: begin
              state_d = S_BAD;
              perr_d  = 1'b1;
            end
          endcase
        end
        S_NUM: begin
          unique case (1'b1)
            is_dig: acc_d = acc_q * 32'd10 + dig;
            is_sep: begin
              state_d = S_GAP;
              acc_d   = '0;
              neg_d   = 1'b0;
              if (count_q < COUNT_WIDTH'(DEPTH)) begin
                for (int i = 0; i < DEPTH; i++)
                  if (COUNT_WIDTH'(i) == count_q) mem_d[i] = val;
                count_d = count_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            default: begin
              state_d = S_BAD;
              perr_d  = 1'b1;
            end
          endcase
        end
        default: begin
          if (is_sep) state_d = S_GAP;
        end
      endcase
    end
  end

  // Entries at or above the count read as zero so clear needs no wipe.
  always_comb begin
    rd_d = '0;
    if (COUNT_WIDTH'(rd_addr) < count_q) rd_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GAP;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end

  assign rd_data     = rd_q;
  assign num_count   = count_q;
  assign overflow    = ovf_q;
  assign parse_error = perr_q;

`ifdef UART_NUM_PARSER_ECHO_EN
  logic [7:0] edata_q, edata_d, hold_q, hold_d;
  logic       evld_q, evld_d, hvld_q, hvld_d, lf_q, lf_d;
  logic       take;

  // A byte landing while LF is being emitted waits one cycle in hold.
  always_comb begin
    take    = rx_valid && !clear_req;
    edata_d = '0;
    evld_d  = 1'b0;
    hold_d  = hold_q;
    hvld_d  = hvld_q;
    lf_d    = 1'b0;
    if (lf_q) begin
      edata_d = 8'h0A;
      evld_d  = 1'b1;
      if (take && !hvld_q) begin
        hold_d = rx_data;
        hvld_d = 1'b1;
      end
    end else if (hvld_q) begin
      edata_d = hold_q;
      evld_d  = 1'b1;
      lf_d    = (hold_q == 8'h0D);
      hold_d  = rx_data;
      hvld_d  = take;
    end else if (take) begin
      edata_d = rx_data;
      evld_d  = 1'b1;
      lf_d    = (rx_data == 8'h0D);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edata_q <= '0;
      evld_q  <= 1'b0;
      hold_q  <= '0;
      hvld_q  <= 1'b0;
      lf_q    <= 1'b0;
    end else begin
      edata_q <= edata_d;
      evld_q  <= evld_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
      lf_q    <= lf_d;
    end
  end

  assign echo_data  = edata_q;
  assign echo_valid = evld_q;
`else
  assign echo_data  = 8'h00;
  assign echo_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_num_parser.sv
// Self-checking bench for uart_num_parser: vector table, corner sequences,
// and random token streams against a token-level reference model.
module tb_uart_num_parser;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          clear_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic [CW-1:0] num_count;
  logic          overflow;
  logic          parse_error;
  logic [7:0]    echo_data;
  logic          echo_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int perr_cnt = 0;
  int echo_seen = 0;

  uart_num_parser #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .num_count(num_count), .overflow(overflow), .parse_error(parse_error),
    .echo_data(echo_data), .echo_valid(echo_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parse_error) perr_cnt++;
    if (echo_valid) echo_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input byte b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    @(negedge clk);
    rd_addr = AW'(a);
    @(negedge clk);
    v = rd_data;
  endtask

  // Reference: a token is a number iff optional '-' then one or more digits.
  function automatic bit eval_tok(input byte t[$], output logic [31:0] v);
    longint unsigned acc = 0;
    int st = 0;
    bit neg = 0;
    v = 0;
    if (t.size() == 0) return 0;
    if (t[0] == "-") begin
      neg = 1;
      st = 1;
    end
    if (st >= t.size()) return 0;
    for (int i = st; i < t.size(); i++) begin
      if (t[i] < "0" || t[i] > "9") return 0;
      acc = (acc * 10 + longint'(t[i] - "0")) % 64'h1_0000_0000;
    end
    v = neg ? 32'(64'h1_0000_0000 - acc) : 32'(acc);
    return 1;
  endfunction

  typedef struct {
    string       bytes;
    int          cnt;
    int          perr;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] v;
    byte seps[5];
    seps[0] = 8'h20; seps[1] = 8'h2C; seps[2] = 8'h09;
    seps[3] = 8'h0D; seps[4] = 8'h0A;

    vt[0] = '{"3 4\n", 2, 0, 32'd3, 32'd4};
    vt[1] = '{"-1,", 1, 0, 32'hFFFF_FFFF, 32'd0};
    vt[2] = '{"-,", 0, 1, 32'd0, 32'd0};
    vt[3] = '{"12a5 7 ", 1, 1, 32'd7, 32'd0};
    vt[4] = '{"4294967297 ", 1, 0, 32'd1, 32'd0};
    vt[5] = '{"0 -0 ", 2, 0, 32'd0, 32'd0};
    vt[6] = '{"-2147483648\t9\r\n", 2, 0, 32'h8000_0000, 32'd9};
    vt[7] = '{"x- 5-3 --4 88,", 1, 3, 32'd88, 32'd0};

    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("reset_count", 32'(num_count), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_perr", 32'(parse_error), 0);
    chk("reset_echo", 32'(echo_valid), 0);
    rd(0, v);
    chk("reset_rd0", v, 0);

    foreach (vt[k]) begin
      do_clear();
      perr_cnt = 0;
      send_str(vt[k].bytes);
      idle(2);
      chk($sformatf("vec%0d_count", k), 32'(num_count), 32'(vt[k].cnt));
      chk($sformatf("vec%0d_perr", k), 32'(perr_cnt), 32'(vt[k].perr));
      rd(0, v);
      chk($sformatf("vec%0d_e0", k), v, vt[k].e0);
      rd(1, v);
      chk($sformatf("vec%0d_e1", k), v, vt[k].e1);
    end

    // count timing: updated the edge after the separator
    do_clear();
    send("3");
    chk("seq_cnt_after_3", 32'(num_count), 0);
    send(" ");
    chk("seq_cnt_after_sp", 32'(num_count), 1);
    send("4");
    send("\n");
    chk("seq_cnt_after_lf", 32'(num_count), 2);
    @(negedge clk);
    rd_addr = 0;
    @(negedge clk);
    rd_addr = 1;
    chk("seq_rd_lat0", rd_data, 3);
    @(negedge clk);
    chk("seq_rd_lat1", rd_data, 4);

    // fill past DEPTH
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) send_str("1 ");
    idle(1);
    chk("full_count", 32'(num_count), DEPTH);
    chk("full_ovf", 32'(overflow), 1);
    rd(15, v);
    chk("full_e15", v, 1);
    do_clear();
    chk("clr_count", 32'(num_count), 0);
    chk("clr_ovf", 32'(overflow), 0);
    rd(0, v);
    chk("clr_rd0", v, 0);

    // clear together with the committing separator
    send_str("4294967297");
    @(negedge clk);
    rx_data = " ";
    rx_valid = 1'b1;
    clear_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_sep_count", 32'(num_count), 0);
    send(" ");
    idle(1);
    chk("clr_sep_nocommit", 32'(num_count), 0);

    // reset mid-token abandons it
    send_str("55");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(" ");
    idle(1);
    chk("rst_mid_count", 32'(num_count), 0);

`ifdef UART_NUM_PARSER_ECHO_EN
    @(negedge clk);
    rx_data = "5";
    rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h0D;
    chk("echo0_v", 32'(echo_valid), 1);
    chk("echo0_d", 32'(echo_data), 32'h35);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("echo1_d", 32'(echo_data), 32'h0D);
    @(negedge clk);
    chk("echo2_v", 32'(echo_valid), 1);
    chk("echo2_d", 32'(echo_data), 32'h0A);
    @(negedge clk);
    chk("echo3_v", 32'(echo_valid), 0);
`else
    chk("echo_never", 32'(echo_seen), 0);
`endif

    for (int r = 0; r < 6; r++) begin
      byte stream[$];
      logic [31:0] vals[$];
      int exp_perr = 0;
      int ntok = $urandom_range(4, 22);
      do_clear();
      perr_cnt = 0;
      for (int t = 0; t < ntok; t++) begin
        byte tok[$];
        logic [31:0] tv;
        int k = $urandom_range(0, 9);
        if (k < 7) begin
          if ($urandom_range(0, 3) == 0) tok.push_back("-");
          for (int d = $urandom_range(1, 12); d > 0; d--)
            tok.push_back(8'($urandom_range(48, 57)));
        end else begin
          unique case ($urandom_range(0, 3))
            0: tok.push_back("-");
            1: begin
              tok.push_back(8'($urandom_range(48, 57)));
              tok.push_back(8'($urandom_range(97, 122)));
              tok.push_back(8'($urandom_range(48, 57)));
            end
            2: begin
              tok.push_back("-");
              tok.push_back("-");
              tok.push_back("4");
            end
            default: begin
              tok.push_back(8'($urandom_range(48, 57)));
              tok.push_back("-");
            end
          endcase
        end
        if (eval_tok(tok, tv)) vals.push_back(tv);
        else exp_perr++;
        foreach (tok[i]) stream.push_back(tok[i]);
        for (int s = $urandom_range(1, 2); s > 0; s--)
          stream.push_back(seps[$urandom_range(0, 4)]);
      end
      foreach (stream[i]) begin
        send(stream[i]);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);
      chk($sformatf("rnd%0d_count", r), 32'(num_count),
          (vals.size() > DEPTH) ? DEPTH : vals.size());
      chk($sformatf("rnd%0d_ovf", r), 32'(overflow),
          (vals.size() > DEPTH) ? 1 : 0);
      chk($sformatf("rnd%0d_perr", r), 32'(perr_cnt), 32'(exp_perr));
      for (int a = 0; a < DEPTH; a++) begin
        rd(a, v);
        chk($sformatf("rnd%0d_e%0d", r, a), v,
            (a < vals.size()) ? vals[a] : 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
